// File: rtl/params_pkg.sv
// Shared address-width defaults for the memory-management blocks.
package params_pkg;
  localparam int VADDR_WIDTH = 32;
  localparam int PADDR_WIDTH = 32;
endpackage

// File: rtl/tlb.sv
// Fully-associative TLB with round-robin replacement and a blocking
// single-request page-table-walker handshake (IDLE -> WALK -> RESP).
module tlb #(
  parameter int VADDR_WIDTH = params_pkg::VADDR_WIDTH,
  parameter int PADDR_WIDTH = params_pkg::PADDR_WIDTH,
  parameter int NUM_ENTRIES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic [VADDR_WIDTH-1:0] vaddr_i,
  input  logic                   flush_i,
  output logic                   valid_o,
  output logic                   error_o,
  output logic [PADDR_WIDTH-1:0] paddr_o,
  output logic                   ptw_req_o,
  output logic [VADDR_WIDTH-1:0] ptw_vaddr_o,
  input  logic                   ptw_valid_i,
  input  logic                   ptw_error_i,
  input  logic [PADDR_WIDTH-1:0] ptw_paddr_i
);

  localparam int VPN_W = VADDR_WIDTH - 12;
  localparam int PPN_W = PADDR_WIDTH - 12;
  localparam int PTR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                   state_q;
  logic [NUM_ENTRIES-1:0]   entry_valid_q;
  logic [VPN_W-1:0]         entry_vpn_q [NUM_ENTRIES];
  logic [PPN_W-1:0]         entry_ppn_q [NUM_ENTRIES];
  logic [PTR_W-1:0]         ptr_q;
  logic [VADDR_WIDTH-1:0]   vaddr_q;
  logic                     valid_q;
  logic                     error_q;
  logic [PADDR_WIDTH-1:0]   paddr_q;
  logic                     ptw_req_q;

  logic [VPN_W-1:0]         req_vpn_s;
  logic [NUM_ENTRIES-1:0]   match_s;
  logic                     hit_s;
  logic [PPN_W-1:0]         hit_ppn_s;
  logic [PPN_W-1:0]         ptw_ppn_s;
  logic                     ptw_offset_unused_s;

  assign req_vpn_s = vaddr_i[VADDR_WIDTH-1:12];
  assign ptw_ppn_s = ptw_paddr_i[PADDR_WIDTH-1:12];
  // The walker's page offset is implied by the captured request address.
  assign ptw_offset_unused_s = ^ptw_paddr_i[11:0];

  // Lookup: fills only happen on a miss, so at most one entry can match and
  // the PPN can be OR-combined across entries.
  always_comb begin
    hit_ppn_s = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match_s[i] = entry_valid_q[i] && (entry_vpn_q[i] == req_vpn_s);
      hit_ppn_s  = hit_ppn_s | (entry_ppn_q[i] & {PPN_W{match_s[i]}});
    end
    hit_s = |match_s;
  end

  // Control FSM, entry array, replacement pointer and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      entry_valid_q <= '0;
      ptr_q         <= '0;
      vaddr_q       <= '0;
      valid_q       <= 1'b0;
      error_q       <= 1'b0;
      paddr_q       <= '0;
      ptw_req_q     <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entry_vpn_q[i] <= '0;
        entry_ppn_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          valid_q   <= 1'b0;
          error_q   <= 1'b0;
          paddr_q   <= '0;
          ptw_req_q <= 1'b0;
          if (req_i) begin
            vaddr_q <= vaddr_i;
            if (hit_s) begin
              state_q <= RESP;
              valid_q <= 1'b1;
              paddr_q <= {hit_ppn_s, vaddr_i[11:0]};
            end else begin
              state_q   <= WALK;
              ptw_req_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WALK: begin
          if (ptw_error_i) begin
            state_q   <= RESP;
            ptw_req_q <= 1'b0;
            error_q   <= 1'b1;
            valid_q   <= 1'b0;
            paddr_q   <= '0;
          end else if (ptw_valid_i) begin
            state_q   <= RESP;
            ptw_req_q <= 1'b0;
            valid_q   <= 1'b1;
            error_q   <= 1'b0;
            paddr_q   <= {ptw_ppn_s, vaddr_q[11:0]};
            ptr_q     <= (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
            // A simultaneous flush wins over the fill.
            if (!flush_i) begin
              entry_valid_q[ptr_q] <= 1'b1;
              entry_vpn_q[ptr_q]   <= vaddr_q[VADDR_WIDTH-1:12];
              entry_ppn_q[ptr_q]   <= ptw_ppn_s;
            end
          end else begin
            state_q   <= WALK;
            ptw_req_q <= 1'b1;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          valid_q   <= 1'b0;
          error_q   <= 1'b0;
          paddr_q   <= '0;
          ptw_req_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          valid_q   <= 1'b0;
          error_q   <= 1'b0;
          paddr_q   <= '0;
          ptw_req_q <= 1'b0;
        end
      endcase

      if (flush_i) begin
        entry_valid_q <= '0;
      end
    end
  end

  assign valid_o     = valid_q;
  assign error_o     = error_q;
  assign paddr_o     = paddr_q;
  assign ptw_req_o   = ptw_req_q;
  assign ptw_vaddr_o = vaddr_q;

endmodule

// File: tb/tb_tlb.sv
// Directed vector bench for the TLB: a table of requests with hand-computed
// responses plus hand-written reset/reset-mid-walk sequences.
module tb_tlb;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] vaddr_i = 32'h0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        error_o;
  logic [31:0] paddr_o;
  logic        ptw_req_o;
  logic [31:0] ptw_vaddr_o;
  logic        ptw_valid_i = 1'b0;
  logic        ptw_error_i = 1'b0;
  logic [31:0] ptw_paddr_i = 32'h0;

  int tests_run = 0;
  int tests_failed = 0;

  tlb #(.VADDR_WIDTH(32), .PADDR_WIDTH(32), .NUM_ENTRIES(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .vaddr_i     (vaddr_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .error_o     (error_o),
    .paddr_o     (paddr_o),
    .ptw_req_o   (ptw_req_o),
    .ptw_vaddr_o (ptw_vaddr_o),
    .ptw_valid_i (ptw_valid_i),
    .ptw_error_i (ptw_error_i),
    .ptw_paddr_i (ptw_paddr_i)
  );

  always #5 clk_i = ~clk_i;

  // mode: 0 = expected hit, 1 = miss/walker valid, 2 = miss/walker error,
  // 3 = miss/walker valid and error together.
  // flush is asserted on the edge that completes the transaction.
  typedef struct {
    logic [31:0] vaddr;
    logic [1:0]  mode;
    logic [31:0] ptw_paddr;
    logic        flush;
    logic        exp_valid;
    logic        exp_error;
    logic [31:0] exp_paddr;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk_i);
    req_i   = 1'b1;
    vaddr_i = v.vaddr;
    if (v.mode == 2'd0) flush_i = v.flush;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    if (v.mode == 2'd0) begin
      chk({tag, "_hit_ptw_req"}, {31'h0, ptw_req_o}, 32'h0);
    end else begin
      chk({tag, "_walk_ptw_req"}, {31'h0, ptw_req_o}, 32'h1);
      chk({tag, "_walk_ptw_vaddr"}, ptw_vaddr_o, v.vaddr);
      chk({tag, "_walk_valid"}, {31'h0, valid_o}, 32'h0);
      ptw_valid_i = v.mode[0];
      ptw_error_i = v.mode[1];
      ptw_paddr_i = v.ptw_paddr;
      flush_i     = v.flush;
      @(posedge clk_i); #1;
      ptw_valid_i = 1'b0;
      ptw_error_i = 1'b0;
      ptw_paddr_i = 32'h0;
      flush_i     = 1'b0;
      chk({tag, "_resp_ptw_req"}, {31'h0, ptw_req_o}, 32'h0);
    end
    chk({tag, "_valid"}, {31'h0, valid_o}, {31'h0, v.exp_valid});
    chk({tag, "_error"}, {31'h0, error_o}, {31'h0, v.exp_error});
    chk({tag, "_paddr"}, paddr_o, v.exp_paddr);
    req_i = 1'b0;
    @(posedge clk_i); #1;
    chk({tag, "_after_valid"}, {31'h0, valid_o}, 32'h0);
    chk({tag, "_after_error"}, {31'h0, error_o}, 32'h0);
    chk({tag, "_after_paddr"}, paddr_o, 32'h0);
  endtask

  initial begin
    // cold miss, hit, fault, then fills to force wrap-around replacement
    vecs[0]  = '{32'h0000_3123, 2'd1, 32'h0008_A000, 1'b0, 1'b1, 1'b0, 32'h0008_A123};
    vecs[1]  = '{32'h0000_3FF0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0008_AFF0};
    vecs[2]  = '{32'h0001_0000, 2'd2, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
    vecs[3]  = '{32'h0001_0004, 2'd1, 32'h0055_5000, 1'b0, 1'b1, 1'b0, 32'h0055_5004};
    vecs[4]  = '{32'h0000_4010, 2'd1, 32'h0001_1000, 1'b0, 1'b1, 1'b0, 32'h0001_1010};
    vecs[5]  = '{32'h0000_5020, 2'd1, 32'h0002_2000, 1'b0, 1'b1, 1'b0, 32'h0002_2020};
    vecs[6]  = '{32'h0000_6030, 2'd1, 32'h0003_3000, 1'b0, 1'b1, 1'b0, 32'h0003_3030};
    vecs[7]  = '{32'h0000_3456, 2'd1, 32'h0009_9000, 1'b0, 1'b1, 1'b0, 32'h0009_9456};
    vecs[8]  = '{32'h0000_4ABC, 2'd0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0001_1ABC};
    vecs[9]  = '{32'h0000_5FFF, 2'd0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0002_2FFF};
    vecs[10] = '{32'h0000_6000, 2'd0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0003_3000};
    vecs[11] = '{32'h0000_3000, 2'd0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0009_9000};
    // valid and error together: error wins, nothing filled
    vecs[12] = '{32'h0000_7777, 2'd3, 32'h0007_7000, 1'b0, 1'b0, 1'b1, 32'h0};
    // flush at walk completion: response delivered, fill dropped
    vecs[13] = '{32'h0000_7008, 2'd1, 32'h000C_C000, 1'b1, 1'b1, 1'b0, 32'h000C_C008};
    vecs[14] = '{32'h0000_7010, 2'd1, 32'h000D_D000, 1'b0, 1'b1, 1'b0, 32'h000D_D010};
    // flush together with a hit: hit still answered, entry gone afterwards
    vecs[15] = '{32'h0000_7ABC, 2'd0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h000D_DABC};
    vecs[16] = '{32'h0000_7ABC, 2'd1, 32'h000E_E000, 1'b0, 1'b1, 1'b0, 32'h000E_EABC};
    vecs[17] = '{32'h0000_7001, 2'd0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h000E_E001};

    #2;
    chk("reset_valid",     {31'h0, valid_o},   32'h0);
    chk("reset_error",     {31'h0, error_o},   32'h0);
    chk("reset_paddr",     paddr_o,            32'h0);
    chk("reset_ptw_req",   {31'h0, ptw_req_o}, 32'h0);
    chk("reset_ptw_vaddr", ptw_vaddr_o,        32'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // reset in the middle of a walk: request drops immediately, no response
    @(negedge clk_i);
    req_i   = 1'b1;
    vaddr_i = 32'h0000_8000;
    @(posedge clk_i); #1;
    chk("rstwalk_ptw_req_before", {31'h0, ptw_req_o}, 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rstwalk_ptw_req_async",   {31'h0, ptw_req_o}, 32'h0);
    chk("rstwalk_ptw_vaddr_async", ptw_vaddr_o,        32'h0);
    chk("rstwalk_valid_async",     {31'h0, valid_o},   32'h0);
    req_i = 1'b0;
    ptw_valid_i = 1'b1;
    ptw_paddr_i = 32'h0004_4000;
    @(negedge clk_i);
    ptw_valid_i = 1'b0;
    ptw_paddr_i = 32'h0;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("rstwalk_no_resp_valid", {31'h0, valid_o}, 32'h0);
    chk("rstwalk_no_resp_error", {31'h0, error_o}, 32'h0);

    // VPN 7 hit before reset; it must miss now
    run_vec('{32'h0000_7001, 2'd1, 32'h000F_F000, 1'b0, 1'b1, 1'b0, 32'h000F_F001}, "postrst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule

// File: doc/tlb.md
TLB -- requirements
Module: tlb

Interface
REQ-001 SHALL have parameter VADDR_WIDTH, default params_pkg::VADDR_WIDTH (32), virtual address width.
REQ-002 SHALL have parameter PADDR_WIDTH, default params_pkg::PADDR_WIDTH (32), physical address width.
REQ-003 SHALL have parameter NUM_ENTRIES, default 4, fully-associative entry count, power of two, at least 2.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_i, input, 1, translation request; held with vaddr_i stable until response.
REQ-007 SHALL have port vaddr_i, input, VADDR_WIDTH, virtual address; VPN = vaddr_i[VADDR_WIDTH-1:12], offset = vaddr_i[11:0].
REQ-008 SHALL have port flush_i, input, 1, invalidate all entries.
REQ-009 SHALL have port valid_o, output, 1, one-cycle pulse: translation successful.
REQ-010 SHALL have port error_o, output, 1, one-cycle pulse: page fault.
REQ-011 SHALL have port paddr_o, output, PADDR_WIDTH, translated address; meaningful only with valid_o.
REQ-012 SHALL have port ptw_req_o, output, 1, walk request to the page-table walker.
REQ-013 SHALL have port ptw_vaddr_o, output, VADDR_WIDTH, captured miss address driven to the walker.
REQ-014 SHALL have port ptw_valid_i, input, 1, walker success.
REQ-015 SHALL have port ptw_error_i, input, 1, walker fault.
REQ-016 SHALL have port ptw_paddr_i, input, PADDR_WIDTH, walker result; PPN = ptw_paddr_i[PADDR_WIDTH-1:12].

Function
REQ-017 SHALL implement FSM states IDLE, WALK, RESP.
REQ-018 Each entry SHALL hold a valid bit, a VPN, and a PPN.
REQ-019 In IDLE, req_i=1 SHALL be accepted; vaddr_i is captured into an internal register.
REQ-020 Lookup SHALL be a combinational compare of vaddr_i VPN against all valid entries in IDLE.
REQ-021 On a hit, the FSM SHALL go to RESP.
REQ-022 On a hit, the block SHALL register paddr_o = {PPN, vaddr_i[11:0]}, truncated to PADDR_WIDTH.
REQ-023 A hit SHALL give valid_o=1 in the cycle after acceptance (1-cycle latency).
REQ-024 On a miss, the FSM SHALL go to WALK.
REQ-025 In WALK, ptw_req_o SHALL be 1 and ptw_vaddr_o SHALL be the captured address; ptw_req_o is 0 in all other states.
REQ-026 In WALK with ptw_valid_i=1, the FSM SHALL write {1, captured VPN, ptw PPN} to the entry at the replacement pointer.
REQ-027 In WALK with ptw_valid_i=1, the replacement pointer SHALL increment, wrapping NUM_ENTRIES-1 to 0.
REQ-028 In WALK with ptw_valid_i=1, the block SHALL register paddr_o = {ptw PPN, captured offset} and go to RESP with valid_o=1.
REQ-029 In WALK with ptw_error_i=1, the block SHALL perform no fill, leave the pointer unchanged, and go to RESP with error_o=1 and paddr_o=0.
REQ-030 If ptw_valid_i and ptw_error_i are both 1, error SHALL take priority.
REQ-031 With a combinational walker, miss latency SHALL be 2 cycles from acceptance to response.
REQ-032 RESP SHALL last exactly one cycle, then the FSM returns to IDLE.
REQ-033 req_i SHALL be ignored outside IDLE.
REQ-034 A new request SHALL be accepted no earlier than the cycle after RESP.
REQ-035 valid_o and error_o SHALL be mutually exclusive.
REQ-036 valid_o, error_o, and paddr_o SHALL be 0 outside RESP.
REQ-037 flush_i SHALL clear all valid bits at the next edge in any state; the replacement pointer is unchanged.
REQ-038 A flush coinciding with a WALK completion SHALL suppress the fill, but the response SHALL still be delivered.
REQ-039 A flush coinciding with a hit in IDLE SHALL still deliver the hit response.
REQ-040 VPN matching SHALL never produce duplicate entries, since fills occur only on a miss.

Reset
REQ-041 rst_ni=0 SHALL immediately and asynchronously force IDLE, all valid bits 0, and replacement pointer 0.
REQ-042 rst_ni=0 SHALL immediately force valid_o=0, error_o=0, paddr_o=0, ptw_req_o=0, and ptw_vaddr_o=0.
REQ-043 Reset mid-WALK SHALL abandon the walk with no fill and no response.

Verification
REQ-044 Cold miss: reset, req vaddr 0x0000_3123, walker returns valid with paddr 0x0008_A000 -> ptw_req_o high 1 cycle, then valid_o=1 with paddr_o=0x0008_A123; pointer becomes 1.
REQ-045 Hit: repeat req vaddr 0x0000_3FF0 -> valid_o=1 one cycle after acceptance, paddr_o=0x0008_AFF0, ptw_req_o stays 0.
REQ-046 Fault: req vaddr 0x0001_0000, walker returns error -> error_o=1, paddr_o=0, no entry written, pointer unchanged.
REQ-047 Wrap/replace: fill 5 distinct VPNs with NUM_ENTRIES=4 -> 5th fill overwrites entry 0, so the first VPN misses again and the others hit.
REQ-048 Flush: flush_i during WALK completion for VPN 0x00007 -> valid_o response delivered, but a subsequent req to VPN 0x00007 misses.
REQ-049 Async reset: assert rst_ni low mid-WALK -> ptw_req_o drops immediately, and a prior-hit VPN misses after release.
